// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and next-PC stage for the single-cycle core.
//
// The block holds the PC register and drives the instruction-memory address.
// Each cycle it picks the next PC from the jump/branch flags produced by the
// decoder, the ALU compare results and the immediate/target fields. The PC
// holds while the multi-cycle unit stalls. Issue is suppressed for one boot
// cycle after reset, which covers the registered imem read latency.
//
// Ports:
//   clock, reset             rising-edge clock, synchronous active-high reset
//   stall                    multdiv busy; the PC holds while this is high
//   is_bne .. is_bex         decoded instruction flags
//   alu_ne, alu_lt           ALU compare results ($rd != $rs, $rd < $rs signed)
//   rstatus_nz               $rstatus != 0, the bex condition
//   imm_n [16:0]             N field, two's complement
//   target_t [26:0]          T field, unsigned
//   rd_val [31:0]            jr target
//   address_imem [IMEM_AW-1:0]  instruction fetch address, pc[IMEM_AW-1:0]
//   pc [31:0], pc_plus1 [31:0]  current PC and the jal link value
//   insn_valid               the instruction at pc may commit
//   redirect                 next PC is not pc+1 in this cycle
//
// Build option: define PC_PERF_CTR_EN to add the perf_cycles, perf_retired,
// perf_redirects and perf_stalls counter outputs (32-bit, wrapping).
//
// FSM states:
//   state   | meaning
//   BOOT    | first cycle after reset; pc = 0, nothing commits
//   RUN     | instruction at pc commits unless stall is high
//   STALL   | pc holds for the multi-cycle unit; nothing commits

module pc_fetch_unit #(
    parameter int IMEM_AW = 12
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic               is_bne,
    input  logic               is_blt,
    input  logic               is_j,
    input  logic               is_jal,
    input  logic               is_jr,
    input  logic               is_bex,
    input  logic               alu_ne,
    input  logic               alu_lt,
    input  logic               rstatus_nz,
    input  logic [16:0]        imm_n,
    input  logic [26:0]        target_t,
    input  logic [31:0]        rd_val,
    output logic [IMEM_AW-1:0] address_imem,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus1,
    output logic               insn_valid,
    output logic               redirect
`ifdef PC_PERF_CTR_EN
    ,
    output logic [31:0]        perf_cycles,
    output logic [31:0]        perf_retired,
    output logic [31:0]        perf_redirects,
    output logic [31:0]        perf_stalls
`endif
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] next_pc;
    logic        non_seq;
    logic        br_taken;
    logic        advance;

    // State and PC registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_BOOT;
            pc_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state logic. Leaving STALL always goes through RUN, so the held
    // instruction (and any branch it carries) is evaluated again before pc moves.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = stall ? S_STALL : S_RUN;
            S_RUN:   state_d = stall ? S_STALL : S_RUN;
            S_STALL: state_d = stall ? S_STALL : S_RUN;
            default: state_d = S_BOOT;
        endcase
    end

    // Next-PC resolution, in priority order.
    always_comb begin
        br_taken = (is_bne & alu_ne) | (is_blt & alu_lt);
        non_seq  = 1'b1;
        if (is_jr) begin
            next_pc = rd_val;
        end else if (is_j | is_jal) begin
            next_pc = {5'b0, target_t};
        end else if (is_bex & rstatus_nz) begin
            next_pc = {5'b0, target_t};
        end else if (br_taken) begin
            next_pc = pc_plus1 + {{15{imm_n[16]}}, imm_n};
        end else begin
            next_pc = pc_plus1;
            non_seq = 1'b0;
        end
    end

    // Output logic. A stall in the deciding cycle discards the redirect.
    always_comb begin
        insn_valid = (state_q == S_RUN);
        advance    = insn_valid & ~stall;
        redirect   = advance & non_seq;
        pc_d       = advance ? next_pc : pc_q;
    end

    assign pc           = pc_q;
    assign pc_plus1     = pc_q + 32'd1;
    assign address_imem = pc_q[IMEM_AW-1:0];

`ifdef PC_PERF_CTR_EN
    logic [31:0] perf_cycles_q, perf_retired_q, perf_redirects_q, perf_stalls_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_cycles_q    <= 32'd0;
            perf_retired_q   <= 32'd0;
            perf_redirects_q <= 32'd0;
            perf_stalls_q    <= 32'd0;
        end else begin
            perf_cycles_q <= perf_cycles_q + 32'd1;
            if (advance) begin
                perf_retired_q <= perf_retired_q + 32'd1;
            end
            if (redirect) begin
                perf_redirects_q <= perf_redirects_q + 32'd1;
            end
            if (state_q == S_STALL) begin
                perf_stalls_q <= perf_stalls_q + 32'd1;
            end
        end
    end

    assign perf_cycles    = perf_cycles_q;
    assign perf_retired   = perf_retired_q;
    assign perf_redirects = perf_redirects_q;
    assign perf_stalls    = perf_stalls_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: directed scenarios followed by random flag,
// stall and reset traffic, all compared against a cycle-level reference model.
module tb_pc_fetch_unit;

    logic        clock, reset, stall;
    logic        is_bne, is_blt, is_j, is_jal, is_jr, is_bex;
    logic        alu_ne, alu_lt, rstatus_nz;
    logic [16:0] imm_n;
    logic [26:0] target_t;
    logic [31:0] rd_val;
    logic [11:0] address_imem;
    logic [31:0] pc, pc_plus1;
    logic        insn_valid, redirect;
`ifdef PC_PERF_CTR_EN
    logic [31:0] perf_cycles, perf_retired, perf_redirects, perf_stalls;
`endif

    pc_fetch_unit #(.IMEM_AW(12)) dut (
        .clock(clock), .reset(reset), .stall(stall),
        .is_bne(is_bne), .is_blt(is_blt), .is_j(is_j), .is_jal(is_jal),
        .is_jr(is_jr), .is_bex(is_bex),
        .alu_ne(alu_ne), .alu_lt(alu_lt), .rstatus_nz(rstatus_nz),
        .imm_n(imm_n), .target_t(target_t), .rd_val(rd_val),
        .address_imem(address_imem), .pc(pc), .pc_plus1(pc_plus1),
        .insn_valid(insn_valid), .redirect(redirect)
`ifdef PC_PERF_CTR_EN
        , .perf_cycles(perf_cycles), .perf_retired(perf_retired),
        .perf_redirects(perf_redirects), .perf_stalls(perf_stalls)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: the architectural PC plus two facts about the cycle,
    // "first cycle after reset" and "held by the previous cycle's stall".
    logic [31:0] m_pc;
    bit          m_boot, m_held;
    logic [31:0] m_cyc, m_ret, m_red, m_stl;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_in();
        {is_bne, is_blt, is_j, is_jal, is_jr, is_bex} = 6'b0;
        {alu_ne, alu_lt, rstatus_nz} = 3'b0;
        stall = 1'b0;
        imm_n = 17'd0;
        target_t = 27'd0;
        rd_val = 32'd0;
    endtask

    task automatic model_reset();
        m_pc = 32'd0; m_boot = 1; m_held = 0;
        m_cyc = 0; m_ret = 0; m_red = 0; m_stl = 0;
    endtask

    // One clock cycle: inputs are already applied at the falling edge.
    task automatic step(input bit rst);
        logic [31:0] seq, nxt, sext;
        bit          br, nonseq, commits;
        reset = rst;
        #1;
        seq  = m_pc + 32'd1;
        sext = {{15{imm_n[16]}}, imm_n};
        br   = (is_bne && alu_ne) || (is_blt && alu_lt);
        nonseq = is_jr || is_j || is_jal || (is_bex && rstatus_nz) || br;
        if (is_jr)                      nxt = rd_val;
        else if (is_j || is_jal)        nxt = 32'(target_t);
        else if (is_bex && rstatus_nz)  nxt = 32'(target_t);
        else if (br)                    nxt = seq + sext;
        else                            nxt = seq;
        commits = !m_boot && !m_held;

        check("pc", pc, m_pc);
        check("address_imem", 32'(address_imem), 32'(m_pc[11:0]));
        check("pc_plus1", pc_plus1, seq);
        check("insn_valid", 32'(insn_valid), 32'(commits));
        check("redirect", 32'(redirect), 32'(commits && !stall && nonseq));
`ifdef PC_PERF_CTR_EN
        check("perf_cycles", perf_cycles, m_cyc);
        check("perf_retired", perf_retired, m_ret);
        check("perf_redirects", perf_redirects, m_red);
        check("perf_stalls", perf_stalls, m_stl);
`endif
        @(posedge clock);
        if (rst) begin
            model_reset();
        end else begin
            m_cyc++;
            if (m_held) m_stl++;
            if (commits && !stall) begin
                m_ret++;
                if (nonseq) m_red++;
                m_pc = nxt;
            end
            m_boot = 0;
            m_held = stall;
        end
        @(negedge clock);
    endtask

    task automatic goto_pc(input logic [31:0] a);
        clear_in();
        is_jr = 1'b1;
        rd_val = a;
        step(0);
        clear_in();
    endtask

`ifdef PC_PERF_CTR_EN
    logic [31:0] stl_before;
`endif

    initial begin
        clear_in();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        model_reset();
        reset = 1'b0;

        // Free run from reset: 0 (BOOT), 0, 1, 2, 3.
        check("boot_pc", pc, 32'd0);
        check("boot_valid", 32'(insn_valid), 32'd0);
        check("boot_plus1", pc_plus1, 32'd1);
        step(0); check("run_pc0", pc, 32'd0);
        step(0); check("run_pc1", pc, 32'd1);
        step(0); check("run_pc2", pc, 32'd2);
        step(0); check("run_pc3", pc, 32'd3);

        // Taken / not-taken bne at pc=10 with offset -4.
        goto_pc(32'd10);
        is_bne = 1; alu_ne = 1; imm_n = 17'h1FFFC;
        #1 check("bne_redirect", 32'(redirect), 32'd1);
        step(0); check("bne_taken_pc", pc, 32'd7);
        goto_pc(32'd10);
        is_bne = 1; alu_ne = 0; imm_n = 17'h1FFFC;
        #1 check("bne_nt_redirect", 32'(redirect), 32'd0);
        step(0); check("bne_nt_pc", pc, 32'd11);

        // jal, then jr beating j.
        goto_pc(32'd5);
        is_jal = 1; target_t = 27'h100;
        #1 check("jal_link", pc_plus1, 32'd6);
        step(0); check("jal_pc", pc, 32'h100);
        goto_pc(32'd5);
        is_jr = 1; rd_val = 32'd6; is_j = 1; target_t = 27'h200;
        step(0); check("jr_prio_pc", pc, 32'd6);
        clear_in();

        // Taken blt at pc=20 with a 3-cycle stall.
        goto_pc(32'd20);
`ifdef PC_PERF_CTR_EN
        stl_before = m_stl;
`endif
        is_blt = 1; alu_lt = 1; imm_n = 17'd3; stall = 1;
        for (int i = 0; i < 3; i++) begin
            step(0);
            check("stall_pc", pc, 32'd20);
            check("stall_valid", 32'(insn_valid), 32'd0);
        end
        stall = 0;
        step(0); check("replay_pc", pc, 32'd20);
        check("replay_valid", 32'(insn_valid), 32'd1);
        step(0); check("blt_target", pc, 32'd24);
`ifdef PC_PERF_CTR_EN
        check("perf_stalls_delta", perf_stalls - stl_before, 32'd3);
`endif
        clear_in();

        // PC wrap.
        goto_pc(32'hFFFFFFFF);
        step(0); check("wrap_pc", pc, 32'd0);

        // Reset in the middle of a stall.
        goto_pc(32'd40);
        stall = 1;
        step(0); step(0);
        step(1);
        check("rst_pc", pc, 32'd0);
        check("rst_valid", 32'(insn_valid), 32'd0);
        check("rst_plus1", pc_plus1, 32'd1);
`ifdef PC_PERF_CTR_EN
        check("rst_perf_cycles", perf_cycles, 32'd0);
        check("rst_perf_stalls", perf_stalls, 32'd0);
        check("rst_perf_retired", perf_retired, 32'd0);
        check("rst_perf_redirects", perf_redirects, 32'd0);
`endif
        clear_in();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            is_bne     = ($urandom_range(5) == 0);
            is_blt     = ($urandom_range(5) == 0);
            is_j       = ($urandom_range(7) == 0);
            is_jal     = ($urandom_range(7) == 0);
            is_jr      = ($urandom_range(9) == 0);
            is_bex     = ($urandom_range(6) == 0);
            alu_ne     = 1'($urandom);
            alu_lt     = 1'($urandom);
            rstatus_nz = 1'($urandom);
            imm_n      = 17'($urandom);
            target_t   = 27'($urandom);
            rd_val     = ($urandom_range(3) == 0) ? 32'hFFFFFFFF : $urandom;
            stall      = ($urandom_range(4) == 0);
            step($urandom_range(60) == 0);
        end
        clear_in();
        step(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
